ps2_keyboard_rx: RTL and testbench
==================================

Name: ps2_keyboard_rx

Overview:
Receives PS/2 keyboard frames and delivers decoded scan codes to the MiniAlu `TEC` operation and any other consumer.
- Replaces the ad-hoc PS2 clock/data filtering and the serial2parallel path with a single block on the system Clock.
- Contains input glitch filters, a frame FSM with parity/stop checking, and a prefix decoder for E0/F0.
- Buffers completed keys in a small first-word-fall-through FIFO with a valid/pop handshake.

Parameters:
FILTER_LEN, 8, consecutive identical Clock samples required before a filtered PS2 line changes state
FIFO_DEPTH, 4, number of key entries buffered; power of 2
FIFO_AW, 2, log2(FIFO_DEPTH)
TIMEOUT_CYCLES, 50000, Clock cycles allowed between PS2 falling edges inside a frame (1 ms at 50 MHz)

Ports:
Clock  in  1  system clock
Reset  in  1  asynchronous, active-high reset
iPS2Clk  in  1  raw PS2_CLK pin, asynchronous
iPS2Data  in  1  raw PS2_DATA pin, asynchronous
iPop  in  1  consume head entry; honoured only when oValid=1
oValid  out  1  FIFO non-empty; head entry present on oKey/oBreak/oExtended
oKey  out  8  head scan code
oBreak  out  1  head entry was preceded by F0 (key release)
oExtended  out  1  head entry was preceded by E0
oFrameErr  out  1  one-cycle pulse: parity, stop or timeout error
oOverflow  out  1  one-cycle pulse: completed key dropped because FIFO full
oCount  out  FIFO_AW+1  number of entries held

Behaviour:
- Reset (async, active-high) values:
  - filtered clk=1, filtered data=1; both filter shift registers all ones
  - FSM=IDLE, bit counter=0, shift register=0, prefix flags=0, timeout counter=0
  - FIFO empty: oValid=0, oCount=0, oKey=0, oBreak=0, oExtended=0, oFrameErr=0, oOverflow=0
- Synchronisation and filtering:
  - Each raw pin passes a 2-flop synchroniser, then a FILTER_LEN-bit shift register.
  - Filtered line goes to 1 when the register is all ones, to 0 when all zeros, otherwise holds.
- Edge detect: registered copy of filtered clk; a falling-edge strobe is asserted for one cycle when previous=1 and current=0. Filtered data is sampled on that strobe.
- FSM (advances only on the falling-edge strobe, except timeout):
  - IDLE: data=0 -> DATA, bitcnt=0. Data=1 -> stay in IDLE, no error.
  - DATA: shift in LSB first (shreg <= {data, shreg[7:1]}). After the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: the frame is good iff XOR(shreg, parity)=1 (odd parity) and data=1. Always return to IDLE.
- Timeout: in DATA/PARITY/STOP the counter increments every Clock and clears on each strobe. Reaching TIMEOUT_CYCLES-1 -> IDLE, oFrameErr pulse, prefix flags cleared.
- Good-frame processing, in the STOP cycle:
  - byte=F0: set break flag, no push
  - byte=E0: set extended flag, no push
  - any other byte: push {extended, break, byte}, then clear both flags
- Bad frame: no push, prefix flags cleared, oFrameErr=1 for exactly one cycle.
- Latency: the entry is visible (oValid=1, oKey valid) on the Clock edge after the STOP strobe cycle.
- FIFO behaviour:
  - First-word-fall-through; outputs are driven from the head entry, registered or from a RAM with registered pointers.
  - Pop with oValid=1: head advances, visible the next cycle.
  - Pop while empty: ignored.
  - Push while full with no pop: entry dropped, oOverflow pulse, contents unchanged.
  - Push and pop in the same cycle while full: both accepted, count unchanged, no overflow.
  - Push and pop in the same cycle while non-empty: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - oCount range is 0..FIFO_DEPTH.
- Host-inhibit (clock held low) is not driven; the block is receive-only.

Test Plan:
- Frame 0x1C (start 0, bits LSB first, parity 0, stop 1), PS2 clk period 60 us -> oValid=1, oKey=0x1C, oBreak=0, oExtended=0, oCount=1. Pop -> oValid=0 the next cycle.
- Frames F0,1C -> exactly one entry {break=1, ext=0, key=0x1C}. Frames E0,F0,75 -> one entry {ext=1, break=1, key=0x75}, oCount=1.
- Frame 0x1C with parity bit flipped -> oFrameErr single pulse, oCount stays 0. Next good frame 0x32 -> entry 0x32.
- Five frames 0x16,0x1E,0x26,0x25,0x2E, no pop -> oCount=4, one oOverflow pulse at the fifth. Four pops return 0x16,0x1E,0x26,0x25. Push coinciding with pop while full -> no overflow, order preserved.
- Start bit plus 3 data bits, then clock held high -> oFrameErr after TIMEOUT_CYCLES, FSM in IDLE. Following frame 0x1C is decoded correctly. A 3-cycle low glitch on iPS2Clk (FILTER_LEN=8) -> no strobe, no state change.
- Reset asserted mid-frame after 4 data bits, then released -> all outputs at reset values. Next full frame 0x45 -> oKey=0x45 with no error pulse.

Source files
------------

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx
//    Receive-only PS/2 keyboard front end on the system clock. Raw PS2 clock
//    and data pins are synchronised and glitch filtered, frames are checked
//    for odd parity and the stop bit, E0/F0 prefixes are folded into flags,
//    and completed keys are queued in a small first-word-fall-through FIFO.
//
// Ports
//    Clock       system clock
//    Reset       asynchronous, active-high reset
//    iPS2Clk     raw PS2_CLK pin (asynchronous)
//    iPS2Data    raw PS2_DATA pin (asynchronous)
//    iPop        consume the head entry; ignored while oValid=0
//    oValid      FIFO non-empty; head entry present on oKey/oBreak/oExtended
//    oKey        head scan code (0 while empty)
//    oBreak      head entry was preceded by F0
//    oExtended   head entry was preceded by E0
//    oFrameErr   one-cycle pulse on parity, stop or timeout error
//    oOverflow   one-cycle pulse when a completed key is dropped (FIFO full)
//    oCount      number of entries held, 0..FIFO_DEPTH
//
// Frame FSM states
//    state     | meaning
//    S_IDLE    | waiting for a start bit (data low on a clock falling edge)
//    S_DATA    | shifting in 8 data bits, LSB first
//    S_PARITY  | capturing the parity bit
//    S_STOP    | checking stop bit and parity, then decoding the byte

module ps2_keyboard_rx #(
   parameter int FILTER_LEN     = 8,
   parameter int FIFO_DEPTH     = 4,
   parameter int FIFO_AW        = 2,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               iPS2Clk,
   input  logic               iPS2Data,
   input  logic               iPop,
   output logic               oValid,
   output logic [7:0]         oKey,
   output logic               oBreak,
   output logic               oExtended,
   output logic               oFrameErr,
   output logic               oOverflow,
   output logic [FIFO_AW:0]   oCount
);

   localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } state_t;

   // ---------------------------------------------------------------------
   // Synchronise, filter, edge detect
   // ---------------------------------------------------------------------
   logic [1:0]            clk_sync;
   logic [1:0]            data_sync;
   logic [FILTER_LEN-1:0] clk_sr;
   logic [FILTER_LEN-1:0] data_sr;
   logic                  clk_filt;
   logic                  data_filt;
   logic                  clk_prev;
   logic                  fall_strobe;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         clk_sync  <= '1;
         data_sync <= '1;
         clk_sr    <= '1;
         data_sr   <= '1;
         clk_filt  <= 1'b1;
         data_filt <= 1'b1;
         clk_prev  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[0], iPS2Clk};
         data_sync <= {data_sync[0], iPS2Data};
         clk_sr    <= {clk_sr[FILTER_LEN-2:0], clk_sync[1]};
         data_sr   <= {data_sr[FILTER_LEN-2:0], data_sync[1]};
         // Filtered lines only move on a full run of identical samples.
         if (&clk_sr)
            clk_filt <= 1'b1;
         else if (~|clk_sr)
            clk_filt <= 1'b0;
         if (&data_sr)
            data_filt <= 1'b1;
         else if (~|data_sr)
            data_filt <= 1'b0;
         clk_prev <= clk_filt;
      end
   end

   assign fall_strobe = clk_prev & ~clk_filt;

   // ---------------------------------------------------------------------
   // Frame FSM
   // ---------------------------------------------------------------------
   state_t           state, state_n;
   logic [2:0]       bit_cnt, bit_cnt_n;
   logic [7:0]       shreg, shreg_n;
   logic             par_bit, par_n;
   logic             brk_flag, brk_n;
   logic             ext_flag, ext_n;
   logic [TMO_W-1:0] tmo_cnt, tmo_n;
   logic             frame_err, err_n;
   logic             frame_good;
   logic             push;
   logic [9:0]       push_entry;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state     <= S_IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         par_bit   <= 1'b0;
         brk_flag  <= 1'b0;
         ext_flag  <= 1'b0;
         tmo_cnt   <= '0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         bit_cnt   <= bit_cnt_n;
         shreg     <= shreg_n;
         par_bit   <= par_n;
         brk_flag  <= brk_n;
         ext_flag  <= ext_n;
         tmo_cnt   <= tmo_n;
         frame_err <= err_n;
      end
   end

   // Odd parity over data+parity, sampled stop bit must be high.
   assign frame_good = (^{shreg, par_bit}) & data_filt;
   assign push_entry = {ext_flag, brk_flag, shreg};

   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt;
      shreg_n   = shreg;
      par_n     = par_bit;
      brk_n     = brk_flag;
      ext_n     = ext_flag;
      tmo_n     = tmo_cnt;
      err_n     = 1'b0;
      push      = 1'b0;

      unique case (state)
         S_IDLE: begin
            tmo_n = '0;
            if (fall_strobe && !data_filt) begin
               state_n   = S_DATA;
               bit_cnt_n = '0;
            end
         end
         S_DATA: begin
            if (fall_strobe) begin
               shreg_n = {data_filt, shreg[7:1]};
               if (bit_cnt == 3'd7)
                  state_n = S_PARITY;
               else
                  bit_cnt_n = bit_cnt + 3'd1;
            end
         end
         S_PARITY: begin
            if (fall_strobe) begin
               par_n   = data_filt;
               state_n = S_STOP;
            end
         end
         S_STOP: begin
            if (fall_strobe) begin
               state_n = S_IDLE;
               if (frame_good) begin
                  if (shreg == 8'hF0)
                     brk_n = 1'b1;
                  else if (shreg == 8'hE0)
                     ext_n = 1'b1;
                  else begin
                     push  = 1'b1;
                     brk_n = 1'b0;
                     ext_n = 1'b0;
                  end
               end else begin
                  err_n = 1'b1;
                  brk_n = 1'b0;
                  ext_n = 1'b0;
               end
            end
         end
         default: state_n = S_IDLE;
      endcase

      // Inter-edge watchdog: a stalled frame abandons any pending prefix.
      if (state != S_IDLE) begin
         if (fall_strobe)
            tmo_n = '0;
         else if (tmo_cnt == TMO_LAST) begin
            state_n = S_IDLE;
            err_n   = 1'b1;
            brk_n   = 1'b0;
            ext_n   = 1'b0;
            tmo_n   = '0;
         end else
            tmo_n = tmo_cnt + TMO_W'(1);
      end
   end

   // ---------------------------------------------------------------------
   // Key FIFO (first-word-fall-through)
   // ---------------------------------------------------------------------
   logic [9:0]         mem [FIFO_DEPTH];
   logic [FIFO_AW-1:0] rd_ptr;
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW:0]   count;
   logic               overflow;
   logic               fifo_full;
   logic               fifo_empty;
   logic               do_pop;
   logic               do_push;
   logic               drop;
   logic [9:0]         head;

   assign fifo_full  = (count == CNT_FULL);
   assign fifo_empty = (count == '0);
   assign do_pop     = iPop & ~fifo_empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign do_push    = push & (~fifo_full | do_pop);
   assign drop       = push & fifo_full & ~do_pop;

   always_ff @(posedge Clock) begin
      if (do_push)
         mem[wr_ptr] <= push_entry;
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= drop;
         if (do_push)
            wr_ptr <= wr_ptr + FIFO_AW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + FIFO_AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (FIFO_AW + 1)'(1);
            2'b01:   count <= count - (FIFO_AW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Head is masked while empty so stale RAM contents never leak out.
   assign head      = fifo_empty ? 10'd0 : mem[rd_ptr];
   assign oValid    = ~fifo_empty;
   assign oKey      = head[7:0];
   assign oBreak    = head[8];
   assign oExtended = head[9];
   assign oFrameErr = frame_err;
   assign oOverflow = overflow;
   assign oCount    = count;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: drives PS/2 frames bit by bit and compares the
// FIFO head against a frame-level queue model every cycle while idle.
module tb_ps2_keyboard_rx;
   localparam int TMO   = 300;
   localparam int HALF  = 40;
   localparam int DEPTH = 4;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       iPS2Clk;
   logic       iPS2Data;
   logic       iPop;
   logic       oValid;
   logic [7:0] oKey;
   logic       oBreak;
   logic       oExtended;
   logic       oFrameErr;
   logic       oOverflow;
   logic [2:0] oCount;

   ps2_keyboard_rx #(
      .FILTER_LEN(8), .FIFO_DEPTH(DEPTH), .FIFO_AW(2), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .Clock(Clock), .Reset(Reset), .iPS2Clk(iPS2Clk), .iPS2Data(iPS2Data),
      .iPop(iPop), .oValid(oValid), .oKey(oKey), .oBreak(oBreak),
      .oExtended(oExtended), .oFrameErr(oFrameErr), .oOverflow(oOverflow),
      .oCount(oCount)
   );

   always #10 Clock = ~Clock;

   int         checks = 0;
   int         errors = 0;
   bit         check_en = 1'b0;
   logic [9:0] model_q[$];
   bit         m_brk = 1'b0;
   bit         m_ext = 1'b0;
   int         exp_err = 0;
   int         exp_ovf = 0;
   int         err_pulses = 0;
   int         ovf_pulses = 0;

   task automatic tick(input int n);
      repeat (n) @(posedge Clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic monitor();
      bit         ep = 1'b0;
      bit         op = 1'b0;
      logic [9:0] h;
      forever begin
         @(negedge Clock);
         if (oFrameErr && !ep) err_pulses++;
         if (oOverflow && !op) ovf_pulses++;
         if (oFrameErr && ep) begin
            errors++;
            $display("FAIL frame_err_width: got 2+ cycles expected 1");
         end
         if (oOverflow && op) begin
            errors++;
            $display("FAIL overflow_width: got 2+ cycles expected 1");
         end
         ep = oFrameErr;
         op = oOverflow;
         if (check_en) begin
            h = (model_q.size() != 0) ? model_q[0] : 10'd0;
            chk("cyc_valid", oValid, model_q.size() != 0);
            chk("cyc_key", oKey, h[7:0]);
            chk("cyc_break", oBreak, h[8]);
            chk("cyc_ext", oExtended, h[9]);
            chk("cyc_count", oCount, model_q.size());
            chk("cyc_err_idle", oFrameErr, 0);
            chk("cyc_ovf_idle", oOverflow, 0);
         end
      end
   endtask

   // index 0 start, 1..8 data LSB first, 9 parity (odd), 10 stop
   function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par);
      return {1'b1, (~^b) ^ bad_par, b, 1'b0};
   endfunction

   task automatic send_bits(input logic [10:0] f, input int nbits, input int glitch_idx,
                            input bit pop_at_stop);
      for (int i = 0; i < nbits; i++) begin
         iPS2Data = f[i];
         tick(10);
         if (i == glitch_idx) begin
            iPS2Clk = 1'b0;
            tick(3);
            iPS2Clk = 1'b1;
         end else
            tick(3);
         tick(HALF - 13);
         iPS2Clk = 1'b0;
         if (pop_at_stop && i == 10) begin
            // raw fall -> 2 sync + 8 filter + 1 filt reg: strobe before edge 12
            tick(11);
            iPop = 1'b1;
            tick(1);
            iPop = 1'b0;
            tick(HALF - 12);
         end else
            tick(HALF);
         iPS2Clk = 1'b1;
      end
      iPS2Data = 1'b1;
   endtask

   task automatic model_frame(input logic [7:0] b, input bit good, input bit coincide);
      if (!good) begin
         exp_err++;
         m_brk = 1'b0;
         m_ext = 1'b0;
      end else if (b == 8'hF0)
         m_brk = 1'b1;
      else if (b == 8'hE0)
         m_ext = 1'b1;
      else begin
         if (coincide && model_q.size() > 0) void'(model_q.pop_front());
         if (model_q.size() == DEPTH) exp_ovf++;
         else model_q.push_back({m_ext, m_brk, b});
         m_brk = 1'b0;
         m_ext = 1'b0;
      end
   endtask

   task automatic do_frame(input logic [7:0] b, input bit bad_par, input int glitch_idx,
                           input bit coincide);
      check_en = 1'b0;
      send_bits(frame_bits(b, bad_par), 11, glitch_idx, coincide);
      tick(30);
      model_frame(b, !bad_par, coincide);
      chk("frame_err_pulses", err_pulses, exp_err);
      chk("overflow_pulses", ovf_pulses, exp_ovf);
      check_en = 1'b1;
   endtask

   task automatic do_pop();
      iPop = 1'b1;
      tick(1);
      iPop = 1'b0;
      if (model_q.size() > 0) void'(model_q.pop_front());
   endtask

   logic [7:0] ovf_keys[5];
   logic [7:0] pop_keys[4];

   initial begin
      int n;
      ovf_keys = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
      pop_keys = '{8'h1E, 8'h26, 8'h25, 8'h36};
      Reset = 1'b1; iPS2Clk = 1'b1; iPS2Data = 1'b1; iPop = 1'b0;
      fork
         monitor();
      join_none
      tick(3);
      chk("rst_valid", oValid, 0);
      chk("rst_count", oCount, 0);
      chk("rst_key", oKey, 0);
      chk("rst_err", oFrameErr, 0);
      chk("rst_ovf", oOverflow, 0);
      Reset = 1'b0;
      tick(20);
      check_en = 1'b1;
      tick(5);

      // single make code
      do_frame(8'h1C, 0, -1, 0);
      chk("t1_valid", oValid, 1);
      chk("t1_key", oKey, 8'h1C);
      chk("t1_break", oBreak, 0);
      chk("t1_ext", oExtended, 0);
      chk("t1_count", oCount, 1);
      do_pop();
      chk("t1_pop_valid", oValid, 0);
      do_pop();
      tick(3);
      chk("t1_empty_pop_count", oCount, 0);

      // break prefix
      do_frame(8'hF0, 0, -1, 0);
      chk("t2_prefix_no_push", oValid, 0);
      do_frame(8'h1C, 0, -1, 0);
      chk("t2_key", oKey, 8'h1C);
      chk("t2_break", oBreak, 1);
      chk("t2_ext", oExtended, 0);
      chk("t2_count", oCount, 1);
      do_pop();

      // extended break
      do_frame(8'hE0, 0, -1, 0);
      do_frame(8'hF0, 0, -1, 0);
      do_frame(8'h75, 0, -1, 0);
      chk("t2b_key", oKey, 8'h75);
      chk("t2b_break", oBreak, 1);
      chk("t2b_ext", oExtended, 1);
      chk("t2b_count", oCount, 1);
      do_pop();

      // parity error then recovery
      do_frame(8'h1C, 1, -1, 0);
      chk("t3_err_pulses", err_pulses, 1);
      chk("t3_count", oCount, 0);
      do_frame(8'h32, 0, -1, 0);
      chk("t3_key", oKey, 8'h32);
      do_pop();

      // overflow and simultaneous push/pop while full
      foreach (ovf_keys[i]) do_frame(ovf_keys[i], 0, -1, 0);
      chk("t4_count", oCount, 4);
      chk("t4_ovf_pulses", ovf_pulses, 1);
      chk("t4_head", oKey, 8'h16);
      do_frame(8'h36, 0, -1, 1);
      chk("t4_coincide_ovf", ovf_pulses, 1);
      chk("t4_coincide_count", oCount, 4);
      foreach (pop_keys[i]) begin
         chk("t4_pop_key", oKey, pop_keys[i]);
         do_pop();
      end
      chk("t4_drained", oCount, 0);

      // timeout after start + 3 data bits
      check_en = 1'b0;
      send_bits(frame_bits(8'h1C, 0), 4, -1, 0);
      n = 0;
      while (!oFrameErr && n < TMO + 200) begin
         tick(1);
         n++;
      end
      chk("t5_timeout_window", (n + HALF >= TMO) && (n + HALF <= TMO + 16), 1);
      tick(5);
      model_frame(8'h00, 0, 0);
      chk("t5_err_pulses", err_pulses, exp_err);
      check_en = 1'b1;
      do_frame(8'h1C, 0, -1, 0);
      chk("t5_key", oKey, 8'h1C);
      do_pop();

      // clock glitch inside a frame, then in idle with data low
      do_frame(8'h1C, 0, 4, 0);
      chk("t5g_key", oKey, 8'h1C);
      iPS2Data = 1'b0;
      tick(5);
      iPS2Clk = 1'b0;
      tick(3);
      iPS2Clk = 1'b1;
      tick(20);
      iPS2Data = 1'b1;
      tick(TMO + 50);
      chk("t5g_idle_no_err", err_pulses, exp_err);

      // reset mid-frame with an entry queued
      check_en = 1'b0;
      send_bits(frame_bits(8'hA5, 0), 5, -1, 0);
      Reset = 1'b1;
      tick(2);
      chk("t6_rst_valid", oValid, 0);
      chk("t6_rst_count", oCount, 0);
      chk("t6_rst_key", oKey, 0);
      model_q.delete();
      m_brk = 1'b0;
      m_ext = 1'b0;
      Reset = 1'b0;
      tick(20);
      check_en = 1'b1;
      tick(5);
      do_frame(8'h45, 0, -1, 0);
      chk("t6_key", oKey, 8'h45);
      chk("t6_break", oBreak, 0);
      tick(10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
